// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Purpose : bundles the control-unit <-> datapath signals of the multi-cycle
//           MIPS controller.
// Members : op, funct, zero, overflow, mem_ready   datapath -> control
//           PCWr, IRWr, RegWr, MemWr, MemRd         write/read strobes
//           RegDst, MemToReg, ALUsrc, IsJump,       mux selects
//           IsJAL, IsJR, IsBranch
//           ALUctrl                                 ALU operation
//           state, retired, illegal_op, ovf_fault   status for the CPU top
// Modports: master = control unit, slave = datapath / CPU top.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
   parameter int OP_W      = 6,
   parameter int FUNCT_W   = 6,
   parameter int ALUCTRL_W = 3,
   parameter int CNT_W     = 32
);
   logic [OP_W-1:0]      op;
   logic [FUNCT_W-1:0]   funct;
   logic                 zero;
   logic                 overflow;
   logic                 mem_ready;

   logic                 PCWr;
   logic                 IRWr;
   logic                 RegWr;
   logic                 MemWr;
   logic                 MemRd;
   logic                 RegDst;
   logic                 MemToReg;
   logic                 ALUsrc;
   logic                 IsJump;
   logic                 IsJAL;
   logic                 IsJR;
   logic                 IsBranch;
   logic [ALUCTRL_W-1:0] ALUctrl;
   logic [2:0]           state;
   logic [CNT_W-1:0]     retired;
   logic                 illegal_op;
   logic                 ovf_fault;

   modport master (
      input  op, funct, zero, overflow, mem_ready,
      output PCWr, IRWr, RegWr, MemWr, MemRd,
      output RegDst, MemToReg, ALUsrc, IsJump, IsJAL, IsJR, IsBranch,
      output ALUctrl, state, retired, illegal_op, ovf_fault
   );

   modport slave (
      output op, funct, zero, overflow, mem_ready,
      input  PCWr, IRWr, RegWr, MemWr, MemRd,
      input  RegDst, MemToReg, ALUsrc, IsJump, IsJAL, IsJR, IsBranch,
      input  ALUctrl, state, retired, illegal_op, ovf_fault
   );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Purpose : multi-cycle MIPS control FSM. Sequences each instruction through
//           FETCH -> DECODE -> EXEC -> MEM -> WB, drives the datapath strobes
//           and mux selects, stalls on mem_ready in FETCH/MEM, counts retired
//           instructions and keeps sticky illegal-opcode / overflow flags.
// Ports   : clk     system clock (rising edge)
//           reset   synchronous, active-high; forces every output to 0
//           io_bus  multicycle_control_if.master (datapath handshake + controls)
// ---------------------------------------------------------------------------
module multicycle_control #(
   parameter int OP_W      = 6,
   parameter int FUNCT_W   = 6,
   parameter int ALUCTRL_W = 3,
   parameter int CNT_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_control_if.master  io_bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_XOR = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3);

   // ---------------- instruction decode ----------------
   logic w_is_rtype, w_is_add, w_is_sub, w_is_slt, w_is_jr;
   logic w_is_lw, w_is_sw, w_is_j, w_is_jal, w_is_beq, w_is_bne;
   logic w_is_xori, w_is_addi, w_is_legal, w_branch_taken;

   assign w_is_rtype = (io_bus.op == OP_W'(6'h00));
   assign w_is_add   = w_is_rtype && (io_bus.funct == FUNCT_W'(6'h20));
   assign w_is_sub   = w_is_rtype && (io_bus.funct == FUNCT_W'(6'h22));
   assign w_is_slt   = w_is_rtype && (io_bus.funct == FUNCT_W'(6'h2A));
   assign w_is_jr    = w_is_rtype && (io_bus.funct == FUNCT_W'(6'h08));
   assign w_is_lw    = (io_bus.op == OP_W'(6'h23));
   assign w_is_sw    = (io_bus.op == OP_W'(6'h2B));
   assign w_is_j     = (io_bus.op == OP_W'(6'h02));
   assign w_is_jal   = (io_bus.op == OP_W'(6'h03));
   assign w_is_beq   = (io_bus.op == OP_W'(6'h04));
   assign w_is_bne   = (io_bus.op == OP_W'(6'h05));
   assign w_is_xori  = (io_bus.op == OP_W'(6'h0E));
   assign w_is_addi  = (io_bus.op == OP_W'(6'h08));

   assign w_is_legal = w_is_add | w_is_sub | w_is_slt | w_is_jr | w_is_lw | w_is_sw |
                       w_is_j | w_is_jal | w_is_beq | w_is_bne | w_is_xori | w_is_addi;

   // An overflowing compare cannot be trusted, so it never takes the branch.
   assign w_branch_taken = ((w_is_beq & io_bus.zero) | (w_is_bne & ~io_bus.zero)) &
                           ~io_bus.overflow;

   // ---------------- state ----------------
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_retired;
   logic             r_illegal_op;
   logic             r_ovf_fault;

   logic [2:0]       w_state_next;
   logic             w_retire;
   logic             w_set_illegal;
   logic             w_set_ovf;

   // Process 1: state register, counter and sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_retired    <= '0;
         r_illegal_op <= 1'b0;
         r_ovf_fault  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
         if (w_set_illegal) begin
            r_illegal_op <= 1'b1;
         end
         if (w_set_ovf) begin
            r_ovf_fault <= 1'b1;
         end
      end
   end

   // Process 2: next-state, retire and fault-set decisions
   always_comb begin
      w_state_next  = S_FETCH;
      w_retire      = 1'b0;
      w_set_illegal = 1'b0;
      w_set_ovf     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_state_next = io_bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            if (w_is_j | w_is_jal | w_is_jr) begin
               w_retire = 1'b1;
            end else if (w_is_legal) begin
               w_state_next = S_EXEC;
            end else begin
               w_set_illegal = 1'b1;
            end
         end
         S_EXEC: begin
            if (w_is_beq | w_is_bne) begin
               w_retire = 1'b1;
            end else if (w_is_lw | w_is_sw) begin
               w_state_next = S_MEM;
            end else if ((w_is_add | w_is_addi | w_is_sub) & io_bus.overflow) begin
               // Abandon without writeback; the faulting result is discarded.
               w_set_ovf = 1'b1;
            end else if (w_is_legal) begin
               w_state_next = S_WB;
            end
         end
         S_MEM: begin
            if (w_is_lw | w_is_sw) begin
               if (!io_bus.mem_ready) begin
                  w_state_next = S_MEM;
               end else if (w_is_lw) begin
                  w_state_next = S_WB;
               end else begin
                  w_retire = 1'b1;
               end
            end
         end
         S_WB: begin
            w_retire = 1'b1;
         end
         default: begin
            w_state_next = S_FETCH;
         end
      endcase
   end

   // Process 3: control outputs, forced low while reset is held so that an
   // in-flight store is cancelled in the very cycle reset arrives.
   always_comb begin
      io_bus.PCWr     = 1'b0;
      io_bus.IRWr     = 1'b0;
      io_bus.RegWr    = 1'b0;
      io_bus.MemWr    = 1'b0;
      io_bus.MemRd    = 1'b0;
      io_bus.RegDst   = 1'b0;
      io_bus.MemToReg = 1'b0;
      io_bus.ALUsrc   = 1'b0;
      io_bus.IsJump   = 1'b0;
      io_bus.IsJAL    = 1'b0;
      io_bus.IsJR     = 1'b0;
      io_bus.IsBranch = 1'b0;
      io_bus.ALUctrl  = '0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               io_bus.MemRd = 1'b1;
               io_bus.IRWr  = io_bus.mem_ready;
               io_bus.PCWr  = io_bus.mem_ready;
            end
            S_DECODE: begin
               io_bus.IsJump = w_is_j | w_is_jal;
               io_bus.IsJAL  = w_is_jal;
               io_bus.RegWr  = w_is_jal;
               io_bus.IsJR   = w_is_jr;
               io_bus.PCWr   = w_is_j | w_is_jal | w_is_jr;
            end
            S_EXEC: begin
               if (w_is_lw | w_is_sw | w_is_addi | w_is_add) begin
                  io_bus.ALUctrl = ALU_ADD;
               end else if (w_is_sub | w_is_beq | w_is_bne) begin
                  io_bus.ALUctrl = ALU_SUB;
               end else if (w_is_xori) begin
                  io_bus.ALUctrl = ALU_XOR;
               end else if (w_is_slt) begin
                  io_bus.ALUctrl = ALU_SLT;
               end
               io_bus.ALUsrc   = w_is_lw | w_is_sw | w_is_addi | w_is_xori;
               io_bus.IsBranch = w_branch_taken;
               io_bus.PCWr     = w_branch_taken;
            end
            S_MEM: begin
               io_bus.MemRd = w_is_lw;
               io_bus.MemWr = w_is_sw;
            end
            S_WB: begin
               io_bus.RegWr    = 1'b1;
               io_bus.RegDst   = w_is_rtype;
               io_bus.MemToReg = w_is_lw;
            end
            default: begin
            end
         endcase
      end
   end

   assign io_bus.state      = reset ? 3'd0 : r_state;
   assign io_bus.retired    = reset ? '0 : r_retired;
   assign io_bus.illegal_op = reset ? 1'b0 : r_illegal_op;
   assign io_bus.ovf_fault  = reset ? 1'b0 : r_ovf_fault;

endmodule
